// File: rtl/eltwise_addsub_vec_if.sv
// Stream bundle carrying add/sub beats into the unit and INT8 results out of it.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready valid-ready handshakes; master drives beats and out_ready.
interface eltwise_addsub_vec_if #(
  parameter int LANES     = 4,
  parameter int INT8_SIZE = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_op;
  logic [LANES*INT8_SIZE-1:0] in1;
  logic [LANES*INT8_SIZE-1:0] in2;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*INT8_SIZE-1:0] out;

  modport master (
    output in_valid, in_op, in1, in2, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in_op, in1, in2, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/eltwise_addsub_vec.sv
// Vectorised INT8 quantized elementwise add/sub with TFLite rounding, LANES pairs per beat.
// Latency: 7 register stages; a beat accepted at edge N is consumable at edge N+7.
// Backpressure: global stall, in_ready = !out_valid || out_ready; every stage holds while stalled.
module eltwise_addsub_vec #(
  parameter int LANES      = 4,
  parameter int INT8_SIZE  = 8,
  parameter int INT32_SIZE = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_load,
  output logic                         cfg_ready,
  input  logic signed [INT32_SIZE-1:0] cfg_in1_offset,
  input  logic signed [INT32_SIZE-1:0] cfg_in2_offset,
  input  logic signed [INT32_SIZE-1:0] cfg_out_offset,
  input  logic        [4:0]            cfg_left_shift,
  input  logic signed [INT32_SIZE-1:0] cfg_in1_mult,
  input  logic signed [INT32_SIZE-1:0] cfg_in2_mult,
  input  logic signed [INT32_SIZE-1:0] cfg_out_mult,
  input  logic signed [5:0]            cfg_in1_shift,
  input  logic signed [5:0]            cfg_in2_shift,
  input  logic signed [5:0]            cfg_out_shift,
  input  logic signed [INT32_SIZE-1:0] cfg_act_min,
  input  logic signed [INT32_SIZE-1:0] cfg_act_max,
  eltwise_addsub_vec_if.slave          bus
);
  localparam int W = INT32_SIZE;

  typedef logic signed [W-1:0]   acc_t;
  typedef logic signed [2*W-1:0] wide_t;

  typedef struct packed {
    acc_t              in1_off;
    acc_t              in2_off;
    acc_t              out_off;
    logic [4:0]        lshift;
    acc_t              in1_mult;
    acc_t              in2_mult;
    acc_t              out_mult;
    logic signed [5:0] in1_shift;
    logic signed [5:0] in2_shift;
    logic signed [5:0] out_shift;
    acc_t              act_min;
    acc_t              act_max;
  } cfg_t;

  localparam wide_t NUDGE_POS  = wide_t'(1) <<< (W - 2);
  localparam wide_t NUDGE_NEG  = wide_t'(1) - NUDGE_POS;
  localparam wide_t TRUNC_BIAS = (wide_t'(1) <<< (W - 1)) - wide_t'(1);
  localparam acc_t  ACC_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam acc_t  ACC_MAX    = {1'b0, {(W-1){1'b1}}};

  // Saturating rounding doubling high multiply; only MIN*MIN can overflow the result.
  function automatic acc_t srdhm(acc_t x, acc_t m);
    wide_t p;
    wide_t q;
    p = wide_t'(x) * wide_t'(m);
    q = p + (p[2*W-1] ? NUDGE_NEG : NUDGE_POS);
    // Bias negative sums so the arithmetic shift truncates toward zero.
    if (q[2*W-1]) q = q + TRUNC_BIAS;
    if (x == ACC_MIN && m == ACC_MIN) return ACC_MAX;
    return acc_t'(q >>> (W - 1));
  endfunction

  // Rounding divide by 2^e, ties away from zero; e=0 passes x through.
  function automatic acc_t rdbp(acc_t x, logic [4:0] e);
    acc_t mask;
    acc_t rem;
    acc_t thr;
    mask = (acc_t'(1) <<< e) - acc_t'(1);
    rem  = x & mask;
    thr  = (mask >>> 1) + (x[W-1] ? acc_t'(1) : acc_t'(0));
    return (x >>> e) + ((rem > thr) ? acc_t'(1) : acc_t'(0));
  endfunction

  // Stored shifts are non-positive; anything outside -31..0 pins to the largest exponent.
  function automatic logic [4:0] shift_to_e(logic signed [5:0] s);
    logic [5:0] n;
    n = 6'd0 - s;
    return n[5] ? 5'd31 : n[4:0];
  endfunction

  cfg_t cfg_q, cfg_d;
  logic [6:0] vld_q;
  logic [2:0] op_q;
  logic       advance;
  logic [4:0] e1, e2, eo;

  acc_t s1a_q [LANES], s1a_d [LANES], s1b_q [LANES], s1b_d [LANES];
  acc_t s2a_q [LANES], s2a_d [LANES], s2b_q [LANES], s2b_d [LANES];
  acc_t s3a_q [LANES], s3a_d [LANES], s3b_q [LANES], s3b_d [LANES];
  acc_t s4_q  [LANES], s4_d  [LANES];
  acc_t s5_q  [LANES], s5_d  [LANES];
  acc_t s6_q  [LANES], s6_d  [LANES];
  logic [LANES*INT8_SIZE-1:0] out_q, out_d;

  assign advance       = !vld_q[6] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[6];
  assign bus.out       = out_q;
  assign cfg_ready     = !(|vld_q) && !bus.in_valid;

  assign e1 = shift_to_e(cfg_q.in1_shift);
  assign e2 = shift_to_e(cfg_q.in2_shift);
  assign eo = shift_to_e(cfg_q.out_shift);

  // Capture a new config only when nothing is in flight or arriving.
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_load && cfg_ready) begin
      cfg_d = '{in1_off:   cfg_in1_offset, in2_off:   cfg_in2_offset, out_off:   cfg_out_offset,
                lshift:    cfg_left_shift,
                in1_mult:  cfg_in1_mult,   in2_mult:  cfg_in2_mult,   out_mult:  cfg_out_mult,
                in1_shift: cfg_in1_shift,  in2_shift: cfg_in2_shift,  out_shift: cfg_out_shift,
                act_min:   cfg_act_min,    act_max:   cfg_act_max};
    end
  end

  // Per-lane datapath: each stage's next value is computed from the previous stage register.
  always_comb begin
    out_d = '0;
    for (int k = 0; k < LANES; k++) begin
      s1a_d[k] = (acc_t'(signed'(bus.in1[k*INT8_SIZE +: INT8_SIZE])) + cfg_q.in1_off) << cfg_q.lshift;
      s1b_d[k] = (acc_t'(signed'(bus.in2[k*INT8_SIZE +: INT8_SIZE])) + cfg_q.in2_off) << cfg_q.lshift;
      s2a_d[k] = srdhm(s1a_q[k], cfg_q.in1_mult);
      s2b_d[k] = srdhm(s1b_q[k], cfg_q.in2_mult);
      s3a_d[k] = rdbp(s2a_q[k], e1);
      s3b_d[k] = rdbp(s2b_q[k], e2);
      s4_d[k]  = op_q[2] ? (s3a_q[k] - s3b_q[k]) : (s3a_q[k] + s3b_q[k]);
      s5_d[k]  = srdhm(s4_q[k], cfg_q.out_mult);
      s6_d[k]  = rdbp(s5_q[k], eo) + cfg_q.out_off;
      if (s6_q[k] < cfg_q.act_min)
        out_d[k*INT8_SIZE +: INT8_SIZE] = cfg_q.act_min[INT8_SIZE-1:0];
      else if (s6_q[k] > cfg_q.act_max)
        out_d[k*INT8_SIZE +: INT8_SIZE] = cfg_q.act_max[INT8_SIZE-1:0];
      else
        out_d[k*INT8_SIZE +: INT8_SIZE] = s6_q[k][INT8_SIZE-1:0];
    end
  end

  // Config register and the valid/op shift chain; bubbles travel as ordinary stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
      vld_q <= '0;
      op_q  <= '0;
    end else begin
      cfg_q <= cfg_d;
      if (advance) begin
        vld_q <= {vld_q[5:0], bus.in_valid};
        op_q  <= {op_q[1:0], bus.in_op};
      end
    end
  end

  // Data stage registers, all frozen together while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1a_q <= '{default: '0};
      s1b_q <= '{default: '0};
      s2a_q <= '{default: '0};
      s2b_q <= '{default: '0};
      s3a_q <= '{default: '0};
      s3b_q <= '{default: '0};
      s4_q  <= '{default: '0};
      s5_q  <= '{default: '0};
      s6_q  <= '{default: '0};
      out_q <= '0;
    end else if (advance) begin
      s1a_q <= s1a_d;
      s1b_q <= s1b_d;
      s2a_q <= s2a_d;
      s2b_q <= s2b_d;
      s3a_q <= s3a_d;
      s3b_q <= s3b_d;
      s4_q  <= s4_d;
      s5_q  <= s5_d;
      s6_q  <= s6_d;
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_eltwise_addsub_vec.sv
// Bench for eltwise_addsub_vec: directed cases plus randomized beats against a reference model.
// Latency: accepted-to-consumed distance checked as 7 edges when the output never stalls.
// Backpressure: stall windows and random out_ready; output hold and in_ready checked each cycle.
module tb_eltwise_addsub_vec;
  typedef struct {
    int off1, off2, offo, ls, m1, m2, mo, sh1, sh2, sho, amin, amax;
  } tcfg_t;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    bit          lat;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_load = 1'b0;
  logic cfg_ready;
  logic signed [31:0] cfg_in1_offset = '0, cfg_in2_offset = '0, cfg_out_offset = '0;
  logic        [4:0]  cfg_left_shift = '0;
  logic signed [31:0] cfg_in1_mult = '0, cfg_in2_mult = '0, cfg_out_mult = '0;
  logic signed [5:0]  cfg_in1_shift = '0, cfg_in2_shift = '0, cfg_out_shift = '0;
  logic signed [31:0] cfg_act_min = '0, cfg_act_max = '0;

  eltwise_addsub_vec_if #(.LANES(4), .INT8_SIZE(8)) bus ();

  eltwise_addsub_vec #(.LANES(4), .INT8_SIZE(8), .INT32_SIZE(32)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_ready(cfg_ready),
    .cfg_in1_offset(cfg_in1_offset), .cfg_in2_offset(cfg_in2_offset), .cfg_out_offset(cfg_out_offset),
    .cfg_left_shift(cfg_left_shift),
    .cfg_in1_mult(cfg_in1_mult), .cfg_in2_mult(cfg_in2_mult), .cfg_out_mult(cfg_out_mult),
    .cfg_in1_shift(cfg_in1_shift), .cfg_in2_shift(cfg_in2_shift), .cfg_out_shift(cfg_out_shift),
    .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  tcfg_t       mc;
  sb_t         q[$];
  sb_t         m_e;
  sb_t         m_n;
  bit          lat_mode = 0;
  bit          use_dir = 0;
  logic [31:0] dir_exp = '0;
  bit          rand_rdy = 0;
  int          stall_lo = -1;
  int          stall_hi = -2;
  bit          prev_stall = 0;
  logic [31:0] prev_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on wide integers, straight from the quantization rules.
  function automatic int srdhm_m(int x, int m);
    longint p;
    longint n;
    if (x == int'(32'h8000_0000) && m == int'(32'h8000_0000)) return int'(32'h7FFF_FFFF);
    p = longint'(x) * longint'(m);
    n = (p >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824);
    return int'((p + n) / 64'sd2147483648);
  endfunction

  function automatic int rdbp_m(int x, int e);
    longint d;
    longint h;
    if (e == 0) return x;
    d = longint'(1) << e;
    h = d / 2;
    if (x >= 0) return int'((longint'(x) + h) / d);
    return int'(-((-longint'(x) + h) / d));
  endfunction

  function automatic logic [7:0] ref_lane(bit op, logic [7:0] x1, logic [7:0] x2);
    int a;
    int b;
    int s;
    a = (int'($signed(x1)) + mc.off1) << mc.ls;
    b = (int'($signed(x2)) + mc.off2) << mc.ls;
    a = rdbp_m(srdhm_m(a, mc.m1), -mc.sh1);
    b = rdbp_m(srdhm_m(b, mc.m2), -mc.sh2);
    s = op ? a - b : a + b;
    s = rdbp_m(srdhm_m(s, mc.mo), -mc.sho) + mc.offo;
    if (s < mc.amin) s = mc.amin;
    else if (s > mc.amax) s = mc.amax;
    return s[7:0];
  endfunction

  function automatic logic [31:0] ref_beat(bit op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = ref_lane(op, a[k*8 +: 8], b[k*8 +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] rep(logic [7:0] v);
    return {4{v}};
  endfunction

  function automatic tcfg_t base_cfg();
    tcfg_t c;
    c.off1 = 0; c.off2 = 0; c.offo = 0; c.ls = 20;
    c.m1 = 1 << 30; c.m2 = 1 << 30; c.mo = 1 << 30;
    c.sh1 = 0; c.sh2 = 0; c.sho = -19;
    c.amin = -128; c.amax = 127;
    return c;
  endfunction

  function automatic tcfg_t rand_cfg();
    tcfg_t c;
    c.off1 = int'($urandom_range(0, 256)) - 128;
    c.off2 = int'($urandom_range(0, 256)) - 128;
    c.offo = int'($urandom_range(0, 255)) - 128;
    c.ls   = int'($urandom_range(0, 20));
    c.m1   = int'($urandom_range(32'h7FFF_FFFF, 32'h4000_0000));
    c.m2   = int'($urandom_range(32'h7FFF_FFFF, 32'h4000_0000));
    c.mo   = int'($urandom_range(32'h7FFF_FFFF, 32'h4000_0000));
    c.sh1  = -int'($urandom_range(0, 31));
    c.sh2  = -int'($urandom_range(0, 31));
    c.sho  = -int'($urandom_range(0, 31));
    c.amin = int'($urandom_range(0, 200)) - 128;
    c.amax = c.amin + int'($urandom_range(0, 127 - c.amin));
    return c;
  endfunction

  // Scoreboard: expectations enter on acceptance, leave on consumption; stalls must hold output.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out, prev_out);
      end
      if (bus.out_valid && !bus.out_ready) check("in_ready_stall", bus.in_ready, 0);
      if (bus.in_valid && bus.in_ready) begin
        m_n.exp = use_dir ? dir_exp : ref_beat(bus.in_op, bus.in1, bus.in2);
        m_n.acc = cyc + 1;
        m_n.lat = lat_mode;
        q.push_back(m_n);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("spurious_out", q.size() == 0, 0);
        if (q.size() != 0) begin
          m_e = q.pop_front();
          check("data", bus.out, m_e.exp);
          if (m_e.lat) check("latency", cyc + 1 - m_e.acc, 7);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = bus.out;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      else          bus.out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    end
  end

  task automatic drive_cfg(input tcfg_t c);
    cfg_in1_offset = c.off1; cfg_in2_offset = c.off2; cfg_out_offset = c.offo;
    cfg_left_shift = c.ls[4:0];
    cfg_in1_mult = c.m1; cfg_in2_mult = c.m2; cfg_out_mult = c.mo;
    cfg_in1_shift = c.sh1[5:0]; cfg_in2_shift = c.sh2[5:0]; cfg_out_shift = c.sho[5:0];
    cfg_act_min = c.amin; cfg_act_max = c.amax;
  endtask

  task automatic load_cfg(input tcfg_t c);
    drive_cfg(c);
    cfg_load = 1'b1;
    @(negedge clk);
    check("cfg_ready_at_load", cfg_ready, 1);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    mc = c;
    check("cfg_ready_after_load", cfg_ready, 1);
  endtask

  task automatic send(input bit op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] dexp);
    bit acc;
    int g;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in1      = a;
    bus.in2      = b;
    dir_exp      = dexp;
    acc = 0;
    g   = 0;
    while (!acc && g < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    check("accept", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q.size() != 0 || bus.out_valid) && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    tcfg_t c;
    int    base;
    bus.in_valid = 1'b0;
    bus.in_op    = 1'b0;
    bus.in1      = '0;
    bus.in2      = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_in_ready", bus.in_ready, 1);

    // Directed arithmetic with an always-ready sink.
    load_cfg(base_cfg());
    use_dir = 1; lat_mode = 1;
    send(0, rep(8'd10), rep(8'd4), rep(8'd7));
    drain();
    send(1, rep(8'd10), rep(8'd4), rep(8'd3));
    drain();
    for (int i = 0; i < 4; i++) send(i[0], rep(8'd10), rep(8'd4), (i % 2 == 0) ? rep(8'd7) : rep(8'd3));
    drain();
    send(0, rep(8'hFD), rep(8'd0), rep(8'hFE));
    drain();
    c = base_cfg(); c.offo = 5;
    load_cfg(c);
    send(0, rep(8'd10), rep(8'd4), rep(8'd12));
    drain();
    c = base_cfg(); c.amax = 5;
    load_cfg(c);
    send(0, rep(8'd10), rep(8'd4), rep(8'd5));
    drain();
    c = base_cfg(); c.amin = -1;
    load_cfg(c);
    send(0, rep(8'hFD), rep(8'd0), rep(8'hFF));
    drain();

    // Ten-beat stream with a five-cycle output stall.
    load_cfg(base_cfg());
    use_dir = 0; lat_mode = 0;
    base = cyc;
    stall_lo = base + 8;
    stall_hi = base + 12;
    for (int i = 0; i < 10; i++) send(0, rep(8'(i * 10)), rep(8'(i)), '0);
    drain();

    // A load attempted under an in-flight beat must be ignored.
    use_dir = 1; lat_mode = 1;
    send(0, rep(8'd10), rep(8'd4), rep(8'd7));
    c = base_cfg(); c.amax = 5; c.offo = 3;
    drive_cfg(c);
    cfg_load = 1'b1;
    @(negedge clk);
    check("cfg_busy", cfg_ready, 0);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    send(0, rep(8'd10), rep(8'd4), rep(8'd7));
    drain();

    // Reset in the middle of a stream flushes everything.
    use_dir = 0; lat_mode = 0;
    for (int i = 0; i < 5; i++) send(bit'($urandom_range(0, 1)), $urandom, $urandom, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_out", bus.out, 0);
    check("rst_mid_cfg_ready", cfg_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    check("rst_mid_flush", q.size(), 0);

    // Randomized beats, configs and sink readiness.
    for (int r = 0; r < 5; r++) begin
      load_cfg((r == 0) ? base_cfg() : rand_cfg());
      rand_rdy = 1;
      for (int i = 0; i < 40; i++) begin
        send(bit'($urandom_range(0, 1)), $urandom, $urandom, '0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      rand_rdy = 0;
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/eltwise_addsub_vec.md
Name: eltwise_addsub_vec

Overview:
- Vectorised, back-pressurable INT8 quantized elementwise add/subtract unit, TFLite-compatible arithmetic.
- Processes LANES element pairs per beat.
- The add/sub opcode travels with each beat, so add and sub beats can be interleaved without draining the pipeline.
- Sits between the tensor fetch buffers and the output writeback FIFO. Quantization parameters come from a config register latched by a load strobe.

Parameters:
- LANES, 4, number of element pairs processed per beat.
- INT8_SIZE, 8, element width.
- INT32_SIZE, 32, internal accumulator / parameter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_load  in  1  latch all cfg_* inputs; accepted only when cfg_ready=1.
- cfg_ready  out  1  high when the pipeline holds no valid beat and in_valid=0.
- cfg_in1_offset, cfg_in2_offset, cfg_out_offset  in  32 each  signed zero-point offsets.
- cfg_left_shift  in  5  pre-scale left shift, 0..20.
- cfg_in1_mult, cfg_in2_mult, cfg_out_mult  in  32 each  signed Q31 multipliers, range [2^30, 2^31-1].
- cfg_in1_shift, cfg_in2_shift, cfg_out_shift  in  6 each  signed shift, range -31..0 (right shift = -shift).
- cfg_act_min, cfg_act_max  in  32 each  signed clamp bounds within [-128,127], min<=max.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready.
- in_op  in  1  0=add (in1+in2), 1=sub (in1-in2).
- in1, in2  in  LANES*8 each  packed signed INT8 elements; lane k = bits [8k+7:8k].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out  out  LANES*8  packed signed INT8 results.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out=0, all stage valids=0, config registers=0; cfg_ready=1 and in_ready=1 after reset. Reset mid-operation discards all in-flight beats.
- Config: on cfg_load&&cfg_ready, all cfg_* inputs are registered on that edge. Beats accepted from the next cycle onward use the new values. cfg_load while cfg_ready=0 is ignored. Config is never changed under an in-flight beat.
- Pipeline: 7 register stages, global stall. advance = !out_valid || out_ready; in_ready = advance. With no stall, a beat accepted at edge N gives out_valid at edge N+7. in_op is carried alongside each beat.
- Stalls: when advance=0, every stage holds its value, out and out_valid stay stable, and no beat is lost or duplicated. Bubbles are not compressed. Full throughput is 1 beat per cycle while out_ready=1.
- Per lane, all arithmetic is in 32-bit signed:
  - S1: a = (in1+off1)<<left_shift; b = (in2+off2)<<left_shift.
  - S2: SRDHM(a,m1), SRDHM(b,m2).
  - S3: RDBP by -shift1 / -shift2.
  - S4: s = op ? a'-b' : a'+b', 32-bit wrap.
  - S5: SRDHM(s,mo).
  - S6: RDBP by -shift_o, then + out_offset.
  - S7: clamp to [act_min,act_max]; low 8 bits go to out.
- SRDHM(x,m): p = 64-bit x*m; nudge = p>=0 ? 2^30 : 1-2^30; result = (p+nudge)/2^31 truncated toward zero. If x = m = -2^31, the result saturates to 2^31-1.
- RDBP(x,e): mask = 2^e-1; rem = x&mask; thr = (mask>>1) + (x<0); result = (x>>>e) + (rem>thr). e=0 is an identity.
- Lanes are independent and identical. Lanes share config.

Test Plan:
- Reset/config: rst for 2 cycles -> out_valid=0, out=0, cfg_ready=1. Load cfg: offsets 0, left_shift 20, in mults 2^30 with shift 0, out mult 2^30 with shift -19, act [-128,127] -> cfg_ready stays 1.
- Add: lane0 in1=10, in2=4, op=0 -> out lane0=7 exactly 7 cycles after acceptance. Sub with same operands, op=1 -> 3. Back-to-back beats alternating op=0/1 -> 7,3,7,3 on consecutive cycles.
- Negative rounding: in1=-3, in2=0, op=0 -> -2 (RDBP half rounds away from zero). Offset check: in1=10, in2=4, out_offset=+5 -> 12.
- Clamp: act_max=5, in1=10, in2=4 add -> 5. act_min=-1 with the -3 case -> -1.
- Backpressure: stream 10 beats with out_ready=0 for cycles 8..12 -> in_ready=0 during the stall, out held stable, all 10 results arrive in order with none lost or duplicated.
- Config guard: cfg_load with a beat in flight -> ignored and old results kept. Assert rst mid-stream -> out_valid=0 next cycle and no stale beats emerge afterwards.
